// File: rtl/tr_manual_pulse_gen.sv
// Manual-mode step-pulse generator for the TR drive.
// Produces a square step train (continuous or exactly N pulses), a latched
// direction line and a signed position counter that follows the step rises.
module tr_manual_pulse_gen #(
    parameter int WIDTH_C_P  = 16,
    parameter int MIN_PERIOD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     start_N,
    input  logic                     stop,
    input  logic [2*WIDTH_C_P-1:0]   period_MANUAL,
    input  logic [2*WIDTH_C_P-1:0]   PULSE_NUMBER,
    input  logic                     dir_MANUAL,
    input  logic                     count_MANUAL,
    output logic                     step,
    output logic                     dir,
    output logic                     busy,
    output logic                     done,
    output logic [2*WIDTH_C_P-1:0]   position
);

    localparam int              W2    = 2 * WIDTH_C_P;
    localparam logic [W2-1:0]   MIN_P = W2'(MIN_PERIOD);
    localparam logic [W2-1:0]   ONE   = W2'(1);
    localparam logic [W2-1:0]   ZERO  = W2'(0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_CONT = 2'd1,
        RUN_N    = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [W2-1:0]   period_r, period_nxt_s;
    logic [W2-1:0]   ph_r, ph_nxt_s;
    logic [W2-1:0]   rem_r, rem_nxt_s;
    logic [W2-1:0]   position_r, position_nxt_s;
    logic            step_r, step_nxt_s;
    logic            dir_r, dir_nxt_s;
    logic            busy_r, busy_nxt_s;
    logic            done_r, done_nxt_s;
    logic            last_ph_s;
    logic            enter_s;

    // Requests below the minimum period are raised to it so the high phase is never empty.
    function automatic logic [W2-1:0] clamp_period(input logic [W2-1:0] req);
        logic [W2-1:0] res;
        if (req < MIN_P) begin
            res = MIN_P;
        end else begin
            res = req;
        end
        return res;
    endfunction

    assign step     = step_r;
    assign dir      = dir_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign position = position_r;

    // Next-state, waveform phase, pulse countdown and position update.
    always_comb begin
        state_nxt_s    = state_r;
        period_nxt_s   = period_r;
        ph_nxt_s       = ph_r;
        rem_nxt_s      = rem_r;
        step_nxt_s     = 1'b0;
        dir_nxt_s      = dir_r;
        done_nxt_s     = 1'b0;
        position_nxt_s = position_r;
        enter_s        = 1'b0;
        last_ph_s      = (ph_r == (period_r - ONE));

        case (state_r)
            IDLE: begin
                if (stop) begin
                    state_nxt_s = IDLE;
                end else if (start) begin
                    state_nxt_s = RUN_CONT;
                    enter_s     = 1'b1;
                end else if (start_N && (PULSE_NUMBER != ZERO)) begin
                    state_nxt_s = RUN_N;
                    enter_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN_CONT: begin
                if (stop) begin
                    state_nxt_s = IDLE;
                    ph_nxt_s    = ZERO;
                end else begin
                    ph_nxt_s   = last_ph_s ? ZERO : (ph_r + ONE);
                    step_nxt_s = (ph_nxt_s < (period_r >> 1));
                end
            end
            RUN_N: begin
                if (stop) begin
                    state_nxt_s = IDLE;
                    ph_nxt_s    = ZERO;
                end else if (last_ph_s && (rem_r == ONE)) begin
                    // Final period has completed: leave with a one-cycle done pulse.
                    state_nxt_s = IDLE;
                    ph_nxt_s    = ZERO;
                    rem_nxt_s   = ZERO;
                    done_nxt_s  = 1'b1;
                end else begin
                    ph_nxt_s   = last_ph_s ? ZERO : (ph_r + ONE);
                    step_nxt_s = (ph_nxt_s < (period_r >> 1));
                    if (last_ph_s) begin
                        rem_nxt_s = rem_r - ONE;
                    end else begin
                        rem_nxt_s = rem_r;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
                ph_nxt_s    = ZERO;
            end
        endcase

        // Run parameters are captured once; the first rise shares the start edge.
        if (enter_s) begin
            period_nxt_s = clamp_period(period_MANUAL);
            ph_nxt_s     = ZERO;
            rem_nxt_s    = PULSE_NUMBER;
            dir_nxt_s    = dir_MANUAL;
            step_nxt_s   = 1'b1;
        end else begin
            period_nxt_s = period_nxt_s;
        end

        if (step_nxt_s && !step_r && count_MANUAL) begin
            position_nxt_s = dir_nxt_s ? (position_r + ONE) : (position_r - ONE);
        end else begin
            position_nxt_s = position_r;
        end

        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            period_r   <= ZERO;
            ph_r       <= ZERO;
            rem_r      <= ZERO;
            position_r <= ZERO;
            step_r     <= 1'b0;
            dir_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            period_r   <= period_nxt_s;
            ph_r       <= ph_nxt_s;
            rem_r      <= rem_nxt_s;
            position_r <= position_nxt_s;
            step_r     <= step_nxt_s;
            dir_r      <= dir_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_tr_manual_pulse_gen.sv
// Scoreboard bench for tr_manual_pulse_gen: expected per-cycle outputs are
// derived from the period/pulse-count arithmetic and queued as stimulus is driven.
module tb_tr_manual_pulse_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start_N;
    logic        stop;
    logic [31:0] period_MANUAL;
    logic [31:0] PULSE_NUMBER;
    logic        dir_MANUAL;
    logic        count_MANUAL;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic [31:0] position;

    typedef struct packed {
        logic        step;
        logic        busy;
        logic        done;
        logic        dir;
        logic [31:0] pos;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks;
    int          n_errors;
    logic [31:0] exp_pos;
    logic        exp_dir;
    logic        prev_step;

    tr_manual_pulse_gen #(.WIDTH_C_P(16), .MIN_PERIOD(2)) dut (
        .clk(clk), .rst(rst), .start(start), .start_N(start_N), .stop(stop),
        .period_MANUAL(period_MANUAL), .PULSE_NUMBER(PULSE_NUMBER),
        .dir_MANUAL(dir_MANUAL), .count_MANUAL(count_MANUAL),
        .step(step), .dir(dir), .busy(busy), .done(done), .position(position)
    );

    // 50 MHz clock.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (step,busy,done,dir,pos)", tag, obs, expv);
        end
    endtask

    // Drive one edge's strobes, queue the expectation for that edge, then compare.
    task automatic cyc(input logic s, input logic sn, input logic sp,
                       input logic e_step, input logic e_busy, input logic e_done,
                       input string tag);
        exp_t e;
        exp_t got;
        start   = s;
        start_N = sn;
        stop    = sp;
        if (e_step && !prev_step && count_MANUAL) begin
            exp_pos = exp_dir ? exp_pos + 32'd1 : exp_pos - 32'd1;
        end
        prev_step = e_step;
        e.step = e_step;
        e.busy = e_busy;
        e.done = e_done;
        e.dir  = exp_dir;
        e.pos  = exp_pos;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start   = 1'b0;
        start_N = 1'b0;
        stop    = 1'b0;
        got = sb_q.pop_front();
        check_val(tag, {28'd0, step, busy, done, dir, position}, {28'd0, got});
    endtask

    task automatic run_n(input int preq, input int n, input logic d, input logic c, input string tag);
        int pe;
        pe = (preq < 2) ? 2 : preq;
        period_MANUAL = 32'(preq);
        PULSE_NUMBER  = 32'(n);
        dir_MANUAL    = d;
        count_MANUAL  = c;
        exp_dir       = d;
        for (int k = 0; k < n * pe; k++) begin
            cyc(1'b0, (k == 0), 1'b0, ((k % pe) < (pe / 2)), 1'b1, 1'b0, tag);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {tag, "_done"});
    endtask

    task automatic run_cont(input int preq, input logic d, input logic c, input int ncyc,
                            input bit disturb, input string tag);
        int   pe;
        logic sn;
        logic s;
        pe = (preq < 2) ? 2 : preq;
        period_MANUAL = 32'(preq);
        dir_MANUAL    = d;
        count_MANUAL  = c;
        exp_dir       = d;
        for (int k = 0; k < ncyc; k++) begin
            sn = 1'b0;
            s  = (k == 0);
            if (disturb && (k == 3)) begin
                period_MANUAL = 32'd3;
                dir_MANUAL    = ~d;
                PULSE_NUMBER  = 32'd2;
                sn            = 1'b1;
            end
            if (disturb && (k == 5)) begin
                s = 1'b1;
            end
            cyc(s, sn, 1'b0, ((k % pe) < (pe / 2)), 1'b1, 1'b0, tag);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        exp_pos       = 32'd0;
        exp_dir       = 1'b0;
        prev_step     = 1'b0;
        rst           = 1'b0;
        start         = 1'b0;
        start_N       = 1'b0;
        stop          = 1'b0;
        period_MANUAL = 32'd0;
        PULSE_NUMBER  = 32'd0;
        dir_MANUAL    = 1'b0;
        count_MANUAL  = 1'b0;

        #25;
        check_val("reset_state", {28'd0, step, busy, done, dir, position}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle0");

        // Continuous run, P=10, stopped after three pulses.
        run_cont(10, 1'b1, 1'b1, 30, 1'b0, "cont10");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "cont10_stop");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "cont10_idle");
        check_val("pos_after_cont", {32'd0, position}, 64'd3);

        // N=3 pulses at P=4, then back-to-back clamped run (P=1 -> 2).
        run_n(4, 3, 1'b1, 1'b1, "n3p4");
        check_val("pos_after_n3", {32'd0, position}, 64'd6);
        run_n(1, 2, 1'b1, 1'b1, "clamp_b2b");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "clamp_idle");

        // start_N with zero pulses is ignored.
        PULSE_NUMBER = 32'd0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "n0");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "n0_idle");

        // stop wins over a simultaneous start.
        period_MANUAL = 32'd4;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "stop_start");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "stop_start_idle");

        // Mid-run input changes and start/start_N while busy have no effect.
        run_cont(6, 1'b1, 1'b0, 13, 1'b1, "midrun");

        // Asynchronous reset while step is high.
        check_val("pre_reset_step", {63'd0, step}, 64'd1);
        rst = 1'b0;
        #1;
        check_val("async_reset", {28'd0, step, busy, done, dir, position}, 64'd0);
        exp_pos   = 32'd0;
        exp_dir   = 1'b0;
        prev_step = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "post_reset_idle");

        // Reverse counting wraps below zero; count disabled leaves position alone.
        run_n(5, 2, 1'b0, 1'b1, "rev");
        check_val("pos_wrap", {32'd0, position}, {32'd0, 32'hFFFF_FFFE});
        run_n(3, 3, 1'b1, 1'b0, "nocount");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "final_idle");
        check_val("pos_unchanged", {32'd0, position}, {32'd0, 32'hFFFF_FFFE});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
